// File: rtl/result_display.sv
// Blackjack result display: latches round outcome, holds final sums,
// drives six active-low 7-seg digits, result LED and saturating tallies.
package bj_pkg;
  localparam logic [3:0] S_RESET       = 4'd0;
  localparam logic [3:0] S_DEAL_PLAYER = 4'd1;
  localparam logic [3:0] S_DEAL_DEALER = 4'd2;
  localparam logic [3:0] S_PLAYER_TURN = 4'd3;
  localparam logic [3:0] S_DEALER_TURN = 4'd4;
  localparam logic [3:0] S_RESULT_WIN  = 4'd5;
  localparam logic [3:0] S_RESULT_LOSE = 4'd6;
  localparam logic [3:0] S_RESULT_TIE  = 4'd7;
  localparam logic [1:0] TURN_PLAYER   = 2'd0;
  localparam logic [1:0] TURN_DEALER   = 2'd1;
  localparam logic [1:0] TURN_NONE     = 2'd2;
endpackage

module result_display
  import bj_pkg::*;
#(
  parameter int HAND_W      = 5,
  parameter int STATE_W     = 4,
  parameter int HOLD_CYCLES = 150_000_000,
  parameter int BLINK_DIV   = 12_500_000
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [HAND_W-1:0]  i_playerHandSum,
  input  logic [HAND_W-1:0]  i_dealerHandSum,
  input  logic [STATE_W-1:0] i_gameState,
  input  logic [1:0]         i_turn,
  input  logic               i_clearScore,
  output logic [6:0]         o_hex0,
  output logic [6:0]         o_hex1,
  output logic [6:0]         o_hex2,
  output logic [6:0]         o_hex3,
  output logic [6:0]         o_hex4,
  output logic [6:0]         o_hex5,
  output logic               o_resultValid,
  output logic [1:0]         o_result,
  output logic               o_resultLed,
  output logic [6:0]         o_wins,
  output logic [6:0]         o_losses,
  output logic [6:0]         o_ties
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'b0111111;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = BLANK;
    endcase
  endfunction

  // Tens blanked when zero, units always lit.
  function automatic logic [13:0] twoDig(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] u;
    t = v / 7'd10;
    u = v - t * 7'd10;
    twoDig = {(t == 7'd0) ? BLANK : seg(t[3:0]), seg(u[3:0])};
  endfunction

  function automatic logic [6:0] satInc(input logic [6:0] t);
    satInc = (t == 7'd99) ? t : t + 7'd1;
  endfunction

  logic [STATE_W-1:0] prevState;
  logic [HAND_W-1:0]  snapPlayer;
  logic [HAND_W-1:0]  snapDealer;
  logic [HW-1:0]      holdCnt;
  logic [BW-1:0]      blinkCnt;
  logic [1:0]         capCode;
  logic               capture;
  logic [HAND_W-1:0]  showPlayer;
  logic [HAND_W-1:0]  showDealer;
  logic               conceal;
  logic [13:0]        pDig;
  logic [13:0]        dDig;
  logic [13:0]        wDig;

  always_comb begin
    capCode = 2'b00;
    unique case (1'b1)
      (i_gameState == STATE_W'(S_RESULT_WIN)):  capCode = 2'b01;
      (i_gameState == STATE_W'(S_RESULT_LOSE)): capCode = 2'b10;
      (i_gameState == STATE_W'(S_RESULT_TIE)):  capCode = 2'b11;
      default:                                  capCode = 2'b00;
    endcase
  end

  assign capture = (capCode != 2'b00) && (i_gameState != prevState);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prevState     <= STATE_W'(S_RESET);
      o_resultValid <= 1'b0;
      o_result      <= 2'b00;
      o_resultLed   <= 1'b0;
      snapPlayer    <= '0;
      snapDealer    <= '0;
      holdCnt       <= '0;
      blinkCnt      <= '0;
    end else begin
      prevState <= i_gameState;
      if (capture) begin
        o_resultValid <= 1'b1;
        o_result      <= capCode;
        o_resultLed   <= 1'b1;
        snapPlayer    <= i_playerHandSum;
        snapDealer    <= i_dealerHandSum;
        holdCnt       <= HW'(HOLD_CYCLES - 1);
        blinkCnt      <= '0;
      end else if (o_resultValid) begin
        if (holdCnt == '0) begin
          o_resultValid <= 1'b0;
          o_result      <= 2'b00;
          o_resultLed   <= 1'b0;
          blinkCnt      <= '0;
        end else begin
          holdCnt <= holdCnt - 1'b1;
          if (blinkCnt == BW'(BLINK_DIV - 1)) begin
            blinkCnt    <= '0;
            o_resultLed <= ~o_resultLed;
          end else begin
            blinkCnt <= blinkCnt + 1'b1;
          end
        end
      end
    end
  end

  // Clear dominates a coincident capture.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wins   <= '0;
      o_losses <= '0;
      o_ties   <= '0;
    end else if (i_clearScore) begin
      o_wins   <= '0;
      o_losses <= '0;
      o_ties   <= '0;
    end else if (capture) begin
      if (capCode == 2'b01) o_wins   <= satInc(o_wins);
      if (capCode == 2'b10) o_losses <= satInc(o_losses);
      if (capCode == 2'b11) o_ties   <= satInc(o_ties);
    end
  end

  assign showPlayer = o_resultValid ? snapPlayer : i_playerHandSum;
  assign showDealer = o_resultValid ? snapDealer : i_dealerHandSum;
  assign conceal    = !o_resultValid && (i_turn == TURN_PLAYER);
  assign pDig = twoDig(7'(showPlayer));
  assign dDig = conceal ? {DASH, DASH} : twoDig(7'(showDealer));
  assign wDig = twoDig(o_wins);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_hex0 <= BLANK;
      o_hex1 <= BLANK;
      o_hex2 <= BLANK;
      o_hex3 <= BLANK;
      o_hex4 <= BLANK;
      o_hex5 <= BLANK;
    end else begin
      {o_hex1, o_hex0} <= pDig;
      {o_hex3, o_hex2} <= dDig;
      {o_hex5, o_hex4} <= wDig;
    end
  end

endmodule
